// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
package multdiv_issue_ctrl_pkg;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned RSTATUS_ADDR  = 30;
  localparam int unsigned MULT_EXC_CODE = 4;
  localparam int unsigned DIV_EXC_CODE  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    BUSY    = 2'd2,
    WB_PEND = 2'd3
  } md_state_e;
endpackage

// File: rtl/multdiv_hazard_cmp.sv
// Compares both D/X sources against the in-flight destination and $rstatus.
module multdiv_hazard_cmp
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned RST_ADDR = RSTATUS_ADDR
) (
  input  logic              check_en_i,
  input  logic [ADDR_W-1:0] src_a_i,
  input  logic [ADDR_W-1:0] src_b_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              raw_stall_o
);
  logic hit_a, hit_b;

  // r0 is never written, so a zero destination cannot create a hazard
  assign hit_a = ((rd_i != '0) && (src_a_i == rd_i)) || (src_a_i == ADDR_W'(RST_ADDR));
  assign hit_b = ((rd_i != '0) && (src_b_i == rd_i)) || (src_b_i == ADDR_W'(RST_ADDR));

  assign raw_stall_o = check_en_i && (hit_a || hit_b);
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Sequences the iterative mult/div unit: issue, start pulse, result capture, writeback, RAW stall.
// Optional watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_ADDR_W     = multdiv_issue_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned RSTATUS_ADDR   = multdiv_issue_ctrl_pkg::RSTATUS_ADDR,
  parameter int unsigned MULT_EXC_CODE  = multdiv_issue_ctrl_pkg::MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE   = multdiv_issue_ctrl_pkg::DIV_EXC_CODE,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_is_mult,
  input  logic                  issue_is_div,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  kill,
  input  logic                  src_check_valid,
  input  logic [REG_ADDR_W-1:0] src_a_addr,
  input  logic [REG_ADDR_W-1:0] src_b_addr,
  output logic                  raw_stall,
  output logic                  md_ctrl_mult,
  output logic                  md_ctrl_div,
  input  logic [DATA_W-1:0]     md_result,
  input  logic                  md_result_rdy,
  input  logic                  md_exception,
  input  logic                  wb_pipe_valid,
  output logic                  md_wb_en,
  output logic [REG_ADDR_W-1:0] md_wb_addr,
  output logic [DATA_W-1:0]     md_wb_data,
  output logic                  busy
);
  md_state_e             state_q, state_d;
  logic                  op_mult_q, op_mult_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  exc_q, exc_d;
  logic                  pulse_mult_q, pulse_mult_d;
  logic                  pulse_div_q, pulse_div_d;
  logic                  accept, wb_suppress, inflight;
`ifdef MULTDIV_TIMEOUT_EN
  logic [5:0]            cnt_q, cnt_d;
`endif

  assign accept      = issue_valid && (issue_is_mult ^ issue_is_div) && !kill;
  assign wb_suppress = !exc_q && (rd_q == '0);
  assign inflight    = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    op_mult_d    = op_mult_q;
    rd_d         = rd_q;
    result_d     = result_q;
    exc_d        = exc_q;
    pulse_mult_d = 1'b0;
    pulse_div_d  = 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = START;
          op_mult_d    = issue_is_mult;
          rd_d         = issue_rd;
          exc_d        = 1'b0;
          pulse_mult_d = issue_is_mult;
          pulse_div_d  = issue_is_div;
        end
      end
      START: begin
        state_d = kill ? IDLE : BUSY;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (kill) begin
          state_d = IDLE;
        end else if (md_result_rdy) begin
          state_d  = WB_PEND;
          result_d = md_result;
          exc_d    = md_exception;
`ifdef MULTDIV_TIMEOUT_EN
        end else if (cnt_q == 6'(TIMEOUT_CYCLES - 1)) begin
          state_d = WB_PEND;
          exc_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
`endif
        end
      end
      WB_PEND: begin
        if (kill || wb_suppress || !wb_pipe_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      op_mult_q    <= 1'b0;
      rd_q         <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      pulse_mult_q <= 1'b0;
      pulse_div_q  <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_mult_q    <= op_mult_d;
      rd_q         <= rd_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      pulse_mult_q <= pulse_mult_d;
      pulse_div_q  <= pulse_div_d;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign issue_ready  = (state_q == IDLE);
  assign busy         = inflight;
  assign md_ctrl_mult = pulse_mult_q;
  assign md_ctrl_div  = pulse_div_q;

  // Pipeline owns the port when wb_pipe_valid is high; WB_PEND simply waits
  assign md_wb_en   = (state_q == WB_PEND) && !kill && !wb_pipe_valid && !wb_suppress;
  assign md_wb_addr = !md_wb_en ? '0 :
                      exc_q     ? REG_ADDR_W'(RSTATUS_ADDR) : rd_q;
  assign md_wb_data = !md_wb_en ? '0 :
                      !exc_q    ? result_q :
                      op_mult_q ? DATA_W'(MULT_EXC_CODE) : DATA_W'(DIV_EXC_CODE);

  multdiv_hazard_cmp #(
    .ADDR_W   (REG_ADDR_W),
    .RST_ADDR (RSTATUS_ADDR)
  ) u_hazard (
    .check_en_i  (src_check_valid && inflight && !md_wb_en),
    .src_a_i     (src_a_addr),
    .src_b_i     (src_b_addr),
    .rd_i        (rd_q),
    .raw_stall_o (raw_stall)
  );
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; writebacks are checked by a queue-based scoreboard.
module tb_multdiv_issue_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_is_mult, issue_is_div;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        kill;
  logic        src_check_valid;
  logic [4:0]  src_a_addr, src_b_addr;
  logic        raw_stall;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result;
  logic        md_result_rdy, md_exception;
  logic        wb_pipe_valid;
  logic        md_wb_en;
  logic [4:0]  md_wb_addr;
  logic [31:0] md_wb_data;
  logic        busy;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  wb_t push_e;
  int  checks   = 0;
  int  failures = 0;

  always #5 clock = ~clock;

  multdiv_issue_ctrl #(
    .DATA_W         (32),
    .REG_ADDR_W     (5),
    .RSTATUS_ADDR   (30),
    .MULT_EXC_CODE  (4),
    .DIV_EXC_CODE   (5),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_is_mult   (issue_is_mult),
    .issue_is_div    (issue_is_div),
    .issue_rd        (issue_rd),
    .issue_ready     (issue_ready),
    .kill            (kill),
    .src_check_valid (src_check_valid),
    .src_a_addr      (src_a_addr),
    .src_b_addr      (src_b_addr),
    .raw_stall       (raw_stall),
    .md_ctrl_mult    (md_ctrl_mult),
    .md_ctrl_div     (md_ctrl_div),
    .md_result       (md_result),
    .md_result_rdy   (md_result_rdy),
    .md_exception    (md_exception),
    .wb_pipe_valid   (wb_pipe_valid),
    .md_wb_en        (md_wb_en),
    .md_wb_addr      (md_wb_addr),
    .md_wb_data      (md_wb_data),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
    push_e.addr = a;
    push_e.data = d;
    exp_q.push_back(push_e);
  endtask

  // Accept an op, verify the start pulse, and leave the DUT in its first BUSY cycle
  task automatic issue(input logic m, input logic [4:0] rd, input logic stale_rdy);
    issue_valid   = 1'b1;
    issue_is_mult = m;
    issue_is_div  = !m;
    issue_rd      = rd;
    #1;
    chk("ready_before_issue", issue_ready, 1);
    tick();
    issue_valid   = 1'b0;
    issue_is_mult = 1'b0;
    issue_is_div  = 1'b0;
    chk("pulse_mult", md_ctrl_mult, m);
    chk("pulse_div", md_ctrl_div, !m);
    chk("busy_in_start", busy, 1);
    chk("ready_in_start", issue_ready, 0);
    md_result_rdy = stale_rdy;
    tick();
    md_result_rdy = 1'b0;
    chk("pulse_mult_cleared", md_ctrl_mult, 0);
    chk("pulse_div_cleared", md_ctrl_div, 0);
    chk("busy_after_start", busy, 1);
  endtask

  // Wait lat cycles in BUSY, present one rdy beat, leave the DUT in WB_PEND
  task automatic finish_op(input logic [31:0] res, input logic exc, input int lat);
    repeat (lat) tick();
    md_result_rdy = 1'b1;
    md_result     = res;
    md_exception  = exc;
    tick();
    md_result_rdy = 1'b0;
    md_exception  = 1'b0;
    md_result     = 32'h0;
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && md_wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: addr=%0d data=0x%0h, expected no write at %0t",
                 md_wb_addr, md_wb_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_wb_addr", md_wb_addr, mon_e.addr);
        chk("sb_wb_data", md_wb_data, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; issue_valid = 1'b0; issue_is_mult = 1'b0; issue_is_div = 1'b0;
    issue_rd = '0; kill = 1'b0; src_check_valid = 1'b0; src_a_addr = '0; src_b_addr = '0;
    md_result = '0; md_result_rdy = 1'b0; md_exception = 1'b0; wb_pipe_valid = 1'b0;
    repeat (2) tick();
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl_mult", md_ctrl_mult, 0);
    chk("rst_ctrl_div", md_ctrl_div, 0);
    chk("rst_wb_en", md_wb_en, 0);
    chk("rst_wb_addr", md_wb_addr, 0);
    chk("rst_wb_data", md_wb_data, 0);
    chk("rst_raw_stall", raw_stall, 0);
    reset = 1'b0;
    tick();

    // MUL r3 -> 0x18; stale rdy during START must be ignored
    expect_wb(5'd3, 32'h18);
    issue(1'b1, 5'd3, 1'b1);
    chk("stale_rdy_ignored", md_wb_en, 0);
    finish_op(32'h18, 1'b0, 31);
    chk("mul_wb_en", md_wb_en, 1);
    chk("mul_wb_addr", md_wb_addr, 3);
    chk("mul_wb_data", md_wb_data, 32'h18);
    tick();
    chk("mul_busy_fall", busy, 0);
    chk("mul_ready_back", issue_ready, 1);
    chk("mul_wb_en_off", md_wb_en, 0);

    // DIV with exception -> $rstatus = 5
    expect_wb(5'd30, 32'd5);
    issue(1'b0, 5'd9, 1'b0);
    finish_op(32'h1234, 1'b1, 5);
    chk("div_exc_wb_en", md_wb_en, 1);
    tick();
    // MUL with exception -> $rstatus = 4
    expect_wb(5'd30, 32'd4);
    issue(1'b1, 5'd4, 1'b0);
    finish_op(32'h0, 1'b1, 2);
    chk("mul_exc_wb_en", md_wb_en, 1);
    tick();

    // Pipeline holds the port for 3 cycles; write lands on the 4th
    expect_wb(5'd12, 32'hDEAD_BEEF);
    issue(1'b1, 5'd12, 1'b0);
    repeat (3) tick();
    wb_pipe_valid = 1'b1;
    finish_op(32'hDEAD_BEEF, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("wb_blocked", md_wb_en, 0);
      chk("wb_blocked_busy", busy, 1);
      tick();
    end
    wb_pipe_valid = 1'b0;
    #1;
    chk("wb_after_block", md_wb_en, 1);
    tick();
    chk("wb_block_done", busy, 0);

    // RAW hazards on rd=7 and $rstatus
    expect_wb(5'd7, 32'h77);
    issue(1'b1, 5'd7, 1'b0);
    src_check_valid = 1'b1; src_a_addr = 5'd7; src_b_addr = 5'd1; #1;
    chk("raw_src_a_rd", raw_stall, 1);
    src_a_addr = 5'd8; src_b_addr = 5'd30; #1;
    chk("raw_src_b_rstatus", raw_stall, 1);
    src_b_addr = 5'd5; #1;
    chk("raw_no_match", raw_stall, 0);
    src_check_valid = 1'b0; src_a_addr = 5'd7; #1;
    chk("raw_check_invalid", raw_stall, 0);
    src_check_valid = 1'b1; #1;
    wb_pipe_valid = 1'b1;
    finish_op(32'h77, 1'b0, 2);
    chk("raw_in_wb_pend_blocked", raw_stall, 1);
    wb_pipe_valid = 1'b0; #1;
    chk("raw_wb_en", md_wb_en, 1);
    chk("raw_drops_on_write", raw_stall, 0);
    tick();
    chk("raw_idle", raw_stall, 0);
    src_check_valid = 1'b0;

    // rd=0: runs but never writes, and no hazard on r0
    issue(1'b1, 5'd0, 1'b0);
    src_check_valid = 1'b1; src_a_addr = 5'd0; src_b_addr = 5'd0; #1;
    chk("raw_r0", raw_stall, 0);
    src_check_valid = 1'b0;
    finish_op(32'h55, 1'b0, 3);
    chk("r0_no_wb", md_wb_en, 0);
    chk("r0_wb_pend_busy", busy, 1);
    tick();
    chk("r0_idle", busy, 0);

    // kill in BUSY, then a late rdy is ignored
    issue(1'b0, 5'd6, 1'b0);
    tick();
    kill = 1'b1; #1;
    chk("kill_no_wb", md_wb_en, 0);
    tick();
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    chk("kill_ready", issue_ready, 1);
    tick();
    md_result_rdy = 1'b1; md_result = 32'h99;
    tick();
    md_result_rdy = 1'b0;
    chk("late_rdy_no_wb", md_wb_en, 0);
    chk("late_rdy_idle", busy, 0);

    // issue + kill together, both-flags and no-flags requests: none accepted
    issue_valid = 1'b1; issue_is_mult = 1'b1; issue_rd = 5'd2; kill = 1'b1;
    tick();
    kill = 1'b0; issue_valid = 1'b0;
    chk("issue_kill_busy", busy, 0);
    chk("issue_kill_pulse", md_ctrl_mult, 0);
    issue_valid = 1'b1; issue_is_mult = 1'b1; issue_is_div = 1'b1;
    tick();
    chk("both_flags_busy", busy, 0);
    chk("both_flags_pulse", md_ctrl_mult | md_ctrl_div, 0);
    issue_is_mult = 1'b0; issue_is_div = 1'b0;
    tick();
    issue_valid = 1'b0;
    chk("no_flags_busy", busy, 0);

    // kill in START: pulse already out, back to IDLE
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0; issue_is_div = 1'b0;
    chk("start_pulse_div", md_ctrl_div, 1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_start_busy", busy, 0);
    chk("kill_start_no_repulse", md_ctrl_div, 0);

    // kill and rdy in the same BUSY cycle: result dropped
    issue(1'b1, 5'd8, 1'b0);
    kill = 1'b1; md_result_rdy = 1'b1; md_result = 32'hAA;
    tick();
    kill = 1'b0; md_result_rdy = 1'b0;
    chk("kill_rdy_busy", busy, 0);
    tick();
    chk("kill_rdy_no_wb", md_wb_en, 0);

    // DIV with no rdy at all
    issue(1'b0, 5'd11, 1'b0);
`ifdef MULTDIV_TIMEOUT_EN
    expect_wb(5'd30, 32'd5);
    n = 0;
    while (busy === 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 41);
    chk("timeout_idle", busy, 0);
`else
    repeat (60) tick();
    chk("no_timeout_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
`endif

    // reset mid-operation, then stale rdy from the unit
    issue(1'b1, 5'd13, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", issue_ready, 1);
    md_result_rdy = 1'b1; md_result = 32'h13;
    tick();
    md_result_rdy = 1'b0;
    chk("midrst_stale_rdy_busy", busy, 0);
    chk("midrst_stale_rdy_wb", md_wb_en, 0);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
